layer_compositor: RTL and testbench
===================================

// Module: layer_compositor
// PURPOSE
//  Pipelined N-layer pixel compositor and collision monitor; successor to the single-ball/three-obstacle colour mapper.
//  Takes per-layer hit flags and palette indices for the current DrawX/DrawY and picks the highest-priority layer.
//  Maps the winner through a runtime-loadable palette and drives registered VGA_R/G/B.
//  Layer 0 is the player sprite. A layer-0/any-other-layer overlap raises crash, latched per frame and counted.
// PARAMETERS
//  NUM_LAYERS  4   layers composited; layer 0 = player, higher index = lower priority
//  COORD_W     10  width of DrawX/DrawY
//  IDX_W       4   palette index width; palette depth = 2**IDX_W
//  COLOR_W     8   bits per colour channel
//  CNT_W       8   width of crash_count
// PORTS
//  Clk          in   1                   system clock
//  Reset        in   1                   synchronous, active-high reset
//  frame_start  in   1                   1-cycle pulse with first pixel of frame
//  pix_valid    in   1                   DrawX/DrawY/layer inputs valid this cycle
//  DrawX        in   COORD_W             current pixel x
//  DrawY        in   COORD_W             current pixel y
//  layer_hit    in   NUM_LAYERS          bit n: pixel lies inside layer n
//  layer_idx    in   NUM_LAYERS*IDX_W    layer n palette index at [n*IDX_W +: IDX_W]
//  pal_we       in   1                   palette write strobe
//  pal_addr     in   IDX_W               palette write address
//  pal_data     in   3*COLOR_W           {R,G,B} write data
//  out_valid    out  1                   VGA_R/G/B valid (pix_valid delayed 2)
//  VGA_R        out  COLOR_W             red
//  VGA_G        out  COLOR_W             green
//  VGA_B        out  COLOR_W             blue
//  out_x        out  COORD_W             DrawX aligned with VGA outputs
//  out_y        out  COORD_W             DrawY aligned with VGA outputs
//  crash        out  1                   live collision, aligned with VGA outputs
//  crash_frame  out  1                   previous frame had >=1 collision
//  crash_count  out  CNT_W               frames with collision, saturating
// BEHAVIOUR
//  - Reset: all outputs 0, pipeline valids 0, palette entries 0, sticky flag 0. Reset wins over every other input.
//  - Latency 2 cycles, fully pipelined, 1 pixel/clock, no stalls.
//  - S1 register: winner = lowest n with opaque hit. Also registers winner idx, collide, valid, DrawX/Y.
//  - Opaque: layer_hit[n] (see CONFIGURATION). No opaque hit -> idx 0 (palette entry 0 = background).
//  - collide = opaque(0) & |opaque(NUM_LAYERS-1:1); evaluated only when pix_valid.
//  - S2 register: {VGA_R,VGA_G,VGA_B} <= palette[S1 idx]; crash <= S1 collide; out_valid <= S1 valid.
//  - out_valid=0: VGA_R/G/B forced 0 (blanking) and crash=0.
//  - Palette: write-before-read NOT applied. A read and write to the same entry in one cycle returns the old value.
//    A written value is visible to S2 on the next cycle.
//  - Sticky flag sets when S1 collide & S1 valid.
//  - On frame_start: crash_frame <= sticky. If sticky=1, crash_count increments, saturating at 2**CNT_W-1.
//    Sticky then reloads with only this cycle's S1 collide, so a collision coincident with frame_start counts toward the new frame.
//  - frame_start with pix_valid=0 is legal; pipeline contents still drain normally.
//  - Reset mid-frame: pipeline flushed, no partial frame counted.
// CONFIGURATION
//  TRANSPARENCY_EN defined: opaque(n) = layer_hit[n] & (idx_n != 0).
//    Index 0 is transparent for priority and for collision; lower layers show through.
//  TRANSPARENCY_EN undefined: opaque(n) = layer_hit[n]; an index-0 hit draws palette 0 and can collide.
// TESTING
//  1. Reset held 3 clks with random inputs -> all outputs 0; pal read 0 after release.
//  2. Load pal[1]=FF0000, pal[2]=00FF00, pal[0]=000000.
//     Hit layer 2 only with idx 2, pix_valid=1 -> 2 clks later RGB=00FF00, out_valid=1, crash=0.
//  3. Hit layers 0 (idx1) and 3 (idx2) -> RGB=FF0000, crash=1 exactly 2 clks later.
//     Next frame_start -> crash_frame=1, crash_count=1.
//  4. Frame with no overlap then frame_start -> crash_frame=0, count unchanged.
//     Force 300 collision frames with CNT_W=8 -> count holds 255.
//  5. TRANSPARENCY_EN: layer0 idx0 over layer1 idx2 -> RGB=00FF00, crash=0.
//     Without the macro, same stimulus -> RGB=pal[0], crash=1.
//  6. pal_we to addr 2 in the cycle S1 selects idx 2 -> old colour output; next pixel shows new colour.

Source files
------------

// File: rtl/layer_compositor.sv
// ============================================================================
// layer_compositor: 2-stage N-layer priority compositor with runtime palette
// and per-frame player collision monitor. Optional macro: TRANSPARENCY_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module layer_compositor #(
  parameter int NUM_LAYERS = 4,
  parameter int COORD_W    = 10,
  parameter int IDX_W      = 4,
  parameter int COLOR_W    = 8,
  parameter int CNT_W      = 8
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        frame_start,
  input  logic                        pix_valid,
  input  logic [COORD_W-1:0]          DrawX,
  input  logic [COORD_W-1:0]          DrawY,
  input  logic [NUM_LAYERS-1:0]       layer_hit,
  input  logic [NUM_LAYERS*IDX_W-1:0] layer_idx,
  input  logic                        pal_we,
  input  logic [IDX_W-1:0]            pal_addr,
  input  logic [3*COLOR_W-1:0]        pal_data,
  output logic                        out_valid,
  output logic [COLOR_W-1:0]          VGA_R,
  output logic [COLOR_W-1:0]          VGA_G,
  output logic [COLOR_W-1:0]          VGA_B,
  output logic [COORD_W-1:0]          out_x,
  output logic [COORD_W-1:0]          out_y,
  output logic                        crash,
  output logic                        crash_frame,
  output logic [CNT_W-1:0]            crash_count
);

  localparam int              PAL_DEPTH = 2 ** IDX_W;
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  // Stage 1 combinational: opacity, priority select, collision
  logic [NUM_LAYERS-1:0] opaque_d;
  logic [IDX_W-1:0]      win_idx_d;
  logic                  collide_d;

  always_comb begin
    opaque_d = '0;
    for (int n = 0; n < NUM_LAYERS; n++) begin
`ifdef TRANSPARENCY_EN
      opaque_d[n] = layer_hit[n] & (layer_idx[n*IDX_W +: IDX_W] != '0);
`else
      opaque_d[n] = layer_hit[n];
`endif
    end
  end

  // Scan from lowest priority upward so the lowest opaque index wins.
  always_comb begin
    win_idx_d = '0;
    for (int n = NUM_LAYERS - 1; n >= 0; n--) begin
      if (opaque_d[n]) win_idx_d = layer_idx[n*IDX_W +: IDX_W];
    end
  end

  assign collide_d = pix_valid & opaque_d[0] & (|opaque_d[NUM_LAYERS-1:1]);

  logic               s1_valid_q;
  logic               s1_collide_q;
  logic [IDX_W-1:0]   s1_idx_q;
  logic [COORD_W-1:0] s1_x_q;
  logic [COORD_W-1:0] s1_y_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1_valid_q   <= 1'b0;
      s1_collide_q <= 1'b0;
      s1_idx_q     <= '0;
      s1_x_q       <= '0;
      s1_y_q       <= '0;
    end else begin
      s1_valid_q   <= pix_valid;
      s1_collide_q <= collide_d;
      s1_idx_q     <= win_idx_d;
      s1_x_q       <= DrawX;
      s1_y_q       <= DrawY;
    end
  end

  // Palette: S2 samples the pre-write contents when a write hits the same entry.
  logic [3*COLOR_W-1:0] pal_q [PAL_DEPTH];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < PAL_DEPTH; i++) pal_q[i] <= '0;
    end else if (pal_we) begin
      pal_q[pal_addr] <= pal_data;
    end
  end

  logic                 out_valid_q;
  logic [3*COLOR_W-1:0] rgb_q;
  logic                 crash_q;
  logic [COORD_W-1:0]   out_x_q;
  logic [COORD_W-1:0]   out_y_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      out_valid_q <= 1'b0;
      rgb_q       <= '0;
      crash_q     <= 1'b0;
      out_x_q     <= '0;
      out_y_q     <= '0;
    end else begin
      out_valid_q <= s1_valid_q;
      rgb_q       <= s1_valid_q ? pal_q[s1_idx_q] : '0;
      crash_q     <= s1_valid_q & s1_collide_q;
      out_x_q     <= s1_x_q;
      out_y_q     <= s1_y_q;
    end
  end

  // Per-frame collision tracking
  logic             sticky_q;
  logic             crash_frame_q;
  logic [CNT_W-1:0] crash_count_q;
  logic             s1_hit_d;

  assign s1_hit_d = s1_valid_q & s1_collide_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sticky_q      <= 1'b0;
      crash_frame_q <= 1'b0;
      crash_count_q <= '0;
    end else if (frame_start) begin
      crash_frame_q <= sticky_q;
      if (sticky_q && crash_count_q != CNT_MAX) crash_count_q <= crash_count_q + 1'b1;
      sticky_q      <= s1_hit_d;
    end else begin
      sticky_q      <= sticky_q | s1_hit_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign VGA_R       = rgb_q[3*COLOR_W-1 -: COLOR_W];
  assign VGA_G       = rgb_q[2*COLOR_W-1 -: COLOR_W];
  assign VGA_B       = rgb_q[COLOR_W-1   -: COLOR_W];
  assign out_x       = out_x_q;
  assign out_y       = out_y_q;
  assign crash       = crash_q;
  assign crash_frame = crash_frame_q;
  assign crash_count = crash_count_q;

endmodule

`default_nettype wire

// File: tb/tb_layer_compositor.sv
// ============================================================================
// tb_layer_compositor: directed self-checking bench for layer_compositor.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_layer_compositor;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        frame_start;
  logic        pix_valid;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic [3:0]  layer_hit;
  logic [15:0] layer_idx;
  logic        pal_we;
  logic [3:0]  pal_addr;
  logic [23:0] pal_data;
  logic        out_valid;
  logic [7:0]  VGA_R;
  logic [7:0]  VGA_G;
  logic [7:0]  VGA_B;
  logic [9:0]  out_x;
  logic [9:0]  out_y;
  logic        crash;
  logic        crash_frame;
  logic [7:0]  crash_count;

  int total = 0;
  int bad   = 0;

  layer_compositor dut (
    .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .pix_valid(pix_valid),
    .DrawX(DrawX), .DrawY(DrawY), .layer_hit(layer_hit), .layer_idx(layer_idx),
    .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data),
    .out_valid(out_valid), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .out_x(out_x), .out_y(out_y), .crash(crash), .crash_frame(crash_frame),
    .crash_count(crash_count)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    frame_start = 1'b0; pix_valid = 1'b0; layer_hit = '0; layer_idx = '0;
    pal_we = 1'b0; pal_addr = '0; pal_data = '0; DrawX = '0; DrawY = '0;
  endtask

  task automatic pixel(input logic [3:0] hit, input logic [15:0] idx,
                       input logic [9:0] x, input logic [9:0] y);
    pix_valid = 1'b1; layer_hit = hit; layer_idx = idx; DrawX = x; DrawY = y;
  endtask

  task automatic write_pal(input logic [3:0] a, input logic [23:0] d);
    pal_we = 1'b1; pal_addr = a; pal_data = d;
    tick();
    pal_we = 1'b0;
  endtask

  initial begin
    // Reset with random activity on every input
    Reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      frame_start = 1'($urandom); pix_valid = 1'($urandom);
      DrawX = 10'($urandom); DrawY = 10'($urandom);
      layer_hit = 4'($urandom); layer_idx = 16'($urandom);
      pal_we = 1'b1; pal_addr = 4'($urandom); pal_data = 24'($urandom) | 24'h1;
      tick();
    end
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_rgb", {8'd0, VGA_R, VGA_G, VGA_B}, 32'd0);
    check("rst_crash", {31'd0, crash}, 32'd0);
    check("rst_crash_frame", {31'd0, crash_frame}, 32'd0);
    check("rst_crash_count", {24'd0, crash_count}, 32'd0);
    check("rst_out_xy", {12'd0, out_x, out_y}, 32'd0);
    Reset = 1'b0;
    idle();

    // Palette must read back zero after reset, for any entry
    for (int e = 0; e < 16; e++) begin
      pixel(4'b0010, 16'(e) << 4, 10'(e), 10'd1);
      tick();
      idle();
      tick();
      check("rst_pal_valid", {31'd0, out_valid}, 32'd1);
      check("rst_pal_rgb", {8'd0, VGA_R, VGA_G, VGA_B}, 32'd0);
    end

    // Load palette
    write_pal(4'd1, 24'hFF0000);
    write_pal(4'd2, 24'h00FF00);
    write_pal(4'd0, 24'h000000);
    write_pal(4'd3, 24'h0000FF);

    // Layer 2 only, idx 2 -> green after exactly 2 clocks
    pixel(4'b0100, 16'h0200, 10'd321, 10'd123);
    tick();
    idle();
    check("lat1_out_valid", {31'd0, out_valid}, 32'd0);
    tick();
    check("l2_rgb", {8'd0, VGA_R, VGA_G, VGA_B}, 32'h0000FF00);
    check("l2_valid", {31'd0, out_valid}, 32'd1);
    check("l2_crash", {31'd0, crash}, 32'd0);
    check("l2_xy", {12'd0, out_x, out_y}, {12'd0, 10'd321, 10'd123});

    // Priority among non-player layers: layer 1 (idx3) over layer 2 (idx2)
    pixel(4'b0110, 16'h0230, 10'd5, 10'd6);
    tick();
    idle();
    tick();
    check("prio_rgb", {8'd0, VGA_R, VGA_G, VGA_B}, 32'h000000FF);
    check("prio_crash", {31'd0, crash}, 32'd0);

    // Player (idx1) over layer 3 (idx2) -> red with crash
    pixel(4'b1001, 16'h2001, 10'd10, 10'd20);
    tick();
    idle();
    check("col_lat1_crash", {31'd0, crash}, 32'd0);
    tick();
    check("col_rgb", {8'd0, VGA_R, VGA_G, VGA_B}, 32'h00FF0000);
    check("col_crash", {31'd0, crash}, 32'd1);
    tick();
    check("blank_crash", {31'd0, crash}, 32'd0);
    check("blank_rgb", {8'd0, VGA_R, VGA_G, VGA_B}, 32'd0);
    check("pre_frame_cf", {31'd0, crash_frame}, 32'd0);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("f1_crash_frame", {31'd0, crash_frame}, 32'd1);
    check("f1_crash_count", {24'd0, crash_count}, 32'd1);

    // Frame without overlap
    pixel(4'b0100, 16'h0200, 10'd1, 10'd1);
    tick();
    idle();
    tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("f2_crash_frame", {31'd0, crash_frame}, 32'd0);
    check("f2_crash_count", {24'd0, crash_count}, 32'd1);

    // Back-to-back collision frames, each pulse coincident with a colliding pixel.
    // First pulse sees sticky=0, second loads sticky, counting starts at the third.
    pixel(4'b1001, 16'h2001, 10'd7, 10'd7);
    frame_start = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    check("burst_count", {24'd0, crash_count}, 32'd11);
    check("burst_cf", {31'd0, crash_frame}, 32'd1);
    for (int i = 0; i < 300; i++) tick();
    check("sat_count", {24'd0, crash_count}, 32'd255);
    idle();
    tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("sat_hold", {24'd0, crash_count}, 32'd255);
    check("sat_cf", {31'd0, crash_frame}, 32'd1);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("quiet_cf", {31'd0, crash_frame}, 32'd0);

    // Player with index 0 over layer 1 idx 2
    pixel(4'b0011, 16'h0020, 10'd50, 10'd60);
    tick();
    idle();
    tick();
`ifdef TRANSPARENCY_EN
    check("transp_rgb", {8'd0, VGA_R, VGA_G, VGA_B}, 32'h0000FF00);
    check("transp_crash", {31'd0, crash}, 32'd0);
`else
    check("opaque_rgb", {8'd0, VGA_R, VGA_G, VGA_B}, 32'h00000000);
    check("opaque_crash", {31'd0, crash}, 32'd1);
`endif

    // Palette write to the entry being read: old colour now, new colour next pixel
    pixel(4'b0100, 16'h0200, 10'd100, 10'd9);
    tick();
    pixel(4'b0100, 16'h0200, 10'd101, 10'd9);
    pal_we = 1'b1; pal_addr = 4'd2; pal_data = 24'h0000FF;
    tick();
    idle();
    check("rw_old_rgb", {8'd0, VGA_R, VGA_G, VGA_B}, 32'h0000FF00);
    check("rw_old_x", {22'd0, out_x}, 32'd100);
    tick();
    check("rw_new_rgb", {8'd0, VGA_R, VGA_G, VGA_B}, 32'h000000FF);
    check("rw_new_x", {22'd0, out_x}, 32'd101);

    // Reset mid-frame with a collision in flight
    pixel(4'b1001, 16'h2001, 10'd3, 10'd3);
    tick();
    idle();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_crash", {31'd0, crash}, 32'd0);
    check("mid_rst_count", {24'd0, crash_count}, 32'd0);
    tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("mid_rst_cf", {31'd0, crash_frame}, 32'd0);
    check("mid_rst_count2", {24'd0, crash_count}, 32'd0);
    pixel(4'b0010, 16'h0010, 10'd0, 10'd0);
    tick();
    idle();
    tick();
    check("mid_rst_pal", {8'd0, VGA_R, VGA_G, VGA_B}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
